dmem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port data memory among `NUM_CORES` processor cores of the multicore build. Each core presents its EX/MEM memory request. The arbiter grants exactly one requester per cycle, muxes that request onto the data-memory port, and stalls every other requester. A per-core lock holds ownership across several cycles for read-modify-write sequences, and a lock timeout guarantees forward progress for the other cores.

---
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin data-memory arbiter with per-core lock and lock timeout
module dmem_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int LOCK_MAX  = 64
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   input  logic [NUM_CORES-1:0]    Core_MemRead,
   input  logic [NUM_CORES-1:0]    Core_MemWrite,
   input  logic [NUM_CORES-1:0]    Core_HalfControl,
   input  logic [NUM_CORES-1:0]    Core_ByteControl,
   input  logic [NUM_CORES-1:0]    Core_Lock,
   input  logic [32*NUM_CORES-1:0] Core_Address,
   input  logic [32*NUM_CORES-1:0] Core_WriteData,
   output logic [NUM_CORES-1:0]    Core_Grant,
   output logic [NUM_CORES-1:0]    Core_Stall,
   output logic [31:0]             Core_ReadData,
   output logic [31:0]             Mem_Address,
   output logic [31:0]             Mem_WriteData,
   output logic                    Mem_MemRead,
   output logic                    Mem_MemWrite,
   output logic                    Mem_HalfControl,
   output logic                    Mem_ByteControl,
   input  logic [31:0]             Mem_ReadData,
   output logic                    Lock_Active,
   output logic [2:0]              Lock_Owner
);
   localparam int CW = $clog2(LOCK_MAX + 1);

   logic [2:0]    rr_ptr, gnt_idx, relock_core;
   logic [CW-1:0] lock_cnt;
   logic          no_relock, gnt_any, acquire;
   logic [7:0]    req_x, lock_x, rd_x, wr_x, hc_x, bc_x;

   function automatic logic [2:0] nxt(input logic [2:0] i);
      return (int'(i) == NUM_CORES - 1) ? 3'd0 : i + 3'd1;
   endfunction

   // vectors padded to 8 so a 3-bit index never selects past the end
   always_comb begin
      req_x   = 8'(Core_MemRead | Core_MemWrite);
      lock_x  = 8'(Core_Lock);
      rd_x    = 8'(Core_MemRead);
      wr_x    = 8'(Core_MemWrite);
      hc_x    = 8'(Core_HalfControl);
      bc_x    = 8'(Core_ByteControl);
      gnt_idx = Lock_Active ? Lock_Owner : 3'd0;
      gnt_any = Lock_Active ? req_x[Lock_Owner] : 1'b0;
      if (!Lock_Active)
         for (int i = NUM_CORES - 1; i >= 0; i--)
            if (req_x[3'((int'(rr_ptr) + i) % NUM_CORES)]) begin
               gnt_any = 1'b1;
               gnt_idx = 3'((int'(rr_ptr) + i) % NUM_CORES);
            end
      acquire = gnt_any & ~Lock_Active & lock_x[gnt_idx] & ~(no_relock & (relock_core == gnt_idx));
   end

   always_comb begin
      Core_Grant = '0;
      for (int k = 0; k < NUM_CORES; k++)
         Core_Grant[k] = gnt_any & (gnt_idx == 3'(k));
      Core_Stall      = req_x[NUM_CORES-1:0] & ~Core_Grant;
      Mem_MemWrite    = gnt_any & wr_x[gnt_idx];
      Mem_MemRead     = gnt_any & rd_x[gnt_idx] & ~wr_x[gnt_idx];
      Mem_HalfControl = gnt_any & hc_x[gnt_idx];
      Mem_ByteControl = gnt_any & bc_x[gnt_idx];
      Mem_Address     = gnt_any ? Core_Address[32*int'(gnt_idx) +: 32] : 32'd0;
      Mem_WriteData   = gnt_any ? Core_WriteData[32*int'(gnt_idx) +: 32] : 32'd0;
      Core_ReadData   = Mem_MemRead ? Mem_ReadData : 32'd0;
   end

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         rr_ptr      <= '0;
         Lock_Active <= 1'b0;
         Lock_Owner  <= '0;
         lock_cnt    <= '0;
         no_relock   <= 1'b0;
         relock_core <= '0;
      end else if (Lock_Active) begin
         if (!lock_x[Lock_Owner] || lock_cnt == CW'(LOCK_MAX)) begin
            Lock_Active <= 1'b0;
            Lock_Owner  <= '0;
            lock_cnt    <= '0;
            rr_ptr      <= nxt(Lock_Owner);
            no_relock   <= lock_x[Lock_Owner];
            relock_core <= Lock_Owner;
         end else begin
            lock_cnt  <= lock_cnt + CW'(1);
            no_relock <= 1'b0;
         end
      end else begin
         no_relock <= 1'b0;
         if (acquire) begin
            Lock_Active <= 1'b1;
            Lock_Owner  <= gnt_idx;
            lock_cnt    <= CW'(1);
         end else if (gnt_any)
            rr_ptr <= nxt(gnt_idx);
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a word-addressed memory
module tb_dmem_arbiter;
   logic         Clk, Rst_n;
   logic [3:0]   Core_MemRead, Core_MemWrite, Core_HalfControl, Core_ByteControl, Core_Lock;
   logic [127:0] Core_Address, Core_WriteData;
   logic [3:0]   Core_Grant, Core_Stall;
   logic [31:0]  Core_ReadData, Mem_Address, Mem_WriteData, Mem_ReadData;
   logic         Mem_MemRead, Mem_MemWrite, Mem_HalfControl, Mem_ByteControl, Lock_Active;
   logic [2:0]   Lock_Owner;
   logic [31:0]  mem [0:255];
   int           n_cmp = 0, n_bad = 0;

   typedef struct {
      logic [3:0]  g, st;
      logic [31:0] rd, ma;
      logic        la, mr, mw;
      logic [2:0]  lo;
   } exp_t;
   exp_t sb [$];

   dmem_arbiter #(.NUM_CORES(4), .LOCK_MAX(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .Core_MemRead(Core_MemRead), .Core_MemWrite(Core_MemWrite),
      .Core_HalfControl(Core_HalfControl), .Core_ByteControl(Core_ByteControl),
      .Core_Lock(Core_Lock), .Core_Address(Core_Address), .Core_WriteData(Core_WriteData),
      .Core_Grant(Core_Grant), .Core_Stall(Core_Stall), .Core_ReadData(Core_ReadData),
      .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
      .Mem_MemRead(Mem_MemRead), .Mem_MemWrite(Mem_MemWrite),
      .Mem_HalfControl(Mem_HalfControl), .Mem_ByteControl(Mem_ByteControl),
      .Mem_ReadData(Mem_ReadData), .Lock_Active(Lock_Active), .Lock_Owner(Lock_Owner)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign Mem_ReadData = mem[Mem_Address[9:2]];
   always @(posedge Clk)
      if (Rst_n && Mem_MemWrite) mem[Mem_Address[9:2]] <= Mem_WriteData;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set(input int k, input logic r, input logic w, input logic l,
                      input logic [31:0] a, input logic [31:0] d);
      Core_MemRead[k] = r;
      Core_MemWrite[k] = w;
      Core_Lock[k] = l;
      Core_Address[32*k +: 32] = a;
      Core_WriteData[32*k +: 32] = d;
   endtask

   task automatic clr;
      Core_MemRead = '0; Core_MemWrite = '0; Core_HalfControl = '0; Core_ByteControl = '0;
      Core_Lock = '0; Core_Address = '0; Core_WriteData = '0;
   endtask

   task automatic push(input logic [3:0] g, input logic [31:0] rdat, input logic la, input logic [2:0] lo);
      exp_t e;
      e.g = g;
      e.st = (Core_MemRead | Core_MemWrite) & ~g;
      e.rd = rdat;
      e.la = la;
      e.lo = lo;
      e.mw = |(g & Core_MemWrite);
      e.mr = |(g & Core_MemRead & ~Core_MemWrite);
      e.ma = '0;
      for (int k = 0; k < 4; k++) if (g[k]) e.ma = Core_Address[32*k +: 32];
      sb.push_back(e);
   endtask

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   always @(negedge Clk)
      if (sb.size() != 0) begin : mon
         exp_t e;
         e = sb.pop_front();
         check("grant", 32'(Core_Grant), 32'(e.g));
         check("stall", 32'(Core_Stall), 32'(e.st));
         check("rdata", Core_ReadData, e.rd);
         check("lock_act", 32'(Lock_Active), 32'(e.la));
         check("lock_own", 32'(Lock_Owner), 32'(e.lo));
         check("mem_rd", 32'(Mem_MemRead), 32'(e.mr));
         check("mem_wr", 32'(Mem_MemWrite), 32'(e.mw));
         check("mem_addr", Mem_Address, e.ma);
      end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      Rst_n = 1'b0;
      clr();
      #2;
      check("rst_grant", 32'(Core_Grant), 0);
      check("rst_stall", 32'(Core_Stall), 0);
      check("rst_mem_ctl", {28'd0, Mem_MemRead, Mem_MemWrite, Mem_HalfControl, Mem_ByteControl}, 0);
      check("rst_mem_addr", Mem_Address, 0);
      check("rst_mem_wdata", Mem_WriteData, 0);
      check("rst_rdata", Core_ReadData, 0);
      check("rst_lock", {28'd0, Lock_Active, Lock_Owner}, 0);
      step();
      Rst_n = 1'b1;

      // round robin with every core reading
      for (int k = 0; k < 4; k++) set(k, 1, 0, 0, 32'(4*k), 0);
      for (int c = 0; c < 5; c++) begin
         push(4'b0001 << (c % 4), 32'h1000_0000 + 32'(c % 4), 0, 0);
         step();
      end
      clr();

      // read and write-with-read to the same word in one cycle
      set(1, 1, 0, 0, 32'h10, 0);
      set(2, 1, 1, 0, 32'h10, 32'hDEADBEEF);
      push(4'b0010, 32'h1000_0004, 0, 0);
      step();
      set(1, 0, 0, 0, 0, 0);
      push(4'b0100, 0, 0, 0);
      step();
      clr();
      set(1, 1, 0, 0, 32'h10, 0);
      push(4'b0010, 32'hDEADBEEF, 0, 0);
      step();
      clr();

      // core 1 holds a lock while cores 0 and 3 wait
      set(1, 1, 0, 1, 32'h14, 0);
      push(4'b0010, 32'h1000_0005, 0, 0);
      step();
      set(0, 1, 0, 0, 32'h0, 0);
      set(3, 1, 0, 0, 32'hC, 0);
      push(4'b0010, 32'h1000_0005, 1, 1);
      step();
      set(1, 0, 1, 1, 32'h14, 32'h1234_5678);
      push(4'b0010, 0, 1, 1);
      step();
      set(1, 0, 0, 0, 0, 0);
      push(4'b0000, 0, 1, 1);
      step();
      push(4'b1000, 32'h1000_0003, 0, 0);
      step();
      push(4'b0001, 32'h1000_0000, 0, 0);
      step();
      clr();

      // core 0 hits the lock timeout twice; core 1 present only the first time
      set(0, 1, 0, 1, 32'h18, 0);
      push(4'b0001, 32'h1000_0006, 0, 0);
      step();
      set(1, 1, 0, 0, 32'h1C, 0);
      for (int c = 0; c < 4; c++) begin
         push(4'b0001, 32'h1000_0006, 1, 0);
         step();
      end
      push(4'b0010, 32'h1000_0007, 0, 0);
      step();
      push(4'b0001, 32'h1000_0006, 0, 0);
      step();
      for (int c = 0; c < 4; c++) begin
         push(4'b0001, 32'h1000_0006, 1, 0);
         step();
      end
      set(1, 0, 0, 0, 0, 0);
      push(4'b0001, 32'h1000_0006, 0, 0);
      step();
      push(4'b0001, 32'h1000_0006, 0, 0);
      step();
      push(4'b0001, 32'h1000_0006, 1, 0);
      step();
      clr();
      push(4'b0000, 0, 1, 0);
      step();

      // reset pulsed while core 3 writes under lock
      set(3, 1, 0, 1, 32'h20, 0);
      push(4'b1000, 32'h1000_0008, 0, 0);
      step();
      set(3, 0, 1, 1, 32'h24, 32'hCAFE_F00D);
      push(4'b1000, 0, 1, 3);
      @(negedge Clk);
      #1;
      Rst_n = 1'b0;
      #1;
      check("rst_mid_lock", {28'd0, Lock_Active, Lock_Owner}, 0);
      check("rst_mid_grant", 32'(Core_Grant), 32'b1000);
      step();
      clr();
      Rst_n = 1'b1;
      check("rst_no_commit", mem[9], 32'h1000_0009);
      for (int k = 0; k < 4; k++) set(k, 1, 0, 0, 32'(4*k), 0);
      push(4'b0001, 32'h1000_0000, 0, 0);
      step();
      push(4'b0010, 32'h1000_0001, 0, 0);
      step();
      clr();
      step();
      check("sb_empty", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
